// File: rtl/decade_timer_ctrl_if.sv
// Control/status bundle between front-panel logic, the BCD digit bank and decade_timer_ctrl.
// Latency: pure wiring, no storage.
// Backpressure: none; every command is a level or single-cycle pulse sampled each clock.
//
// master: front panel / bus side. It drives the commands and forwards digit_q from the counter bank.
// slave : the controller. It drives the digit-bank controls and the status outputs.
interface decade_timer_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  pause;
    logic                  clear;
    logic                  dir_up;
    logic [4*DIGITS-1:0]   preset;
    logic [4*DIGITS-1:0]   digit_q;
    logic [DIGITS-1:0]     cnt_enable;
    logic                  cnt_up;
    logic                  cnt_load;
    logic [4*DIGITS-1:0]   cnt_load_value;
    logic                  busy;
    logic                  done;
    logic [2:0]            state;

    modport master (
        output start, pause, clear, dir_up, preset, digit_q,
        input  cnt_enable, cnt_up, cnt_load, cnt_load_value, busy, done, state
    );

    modport slave (
        input  start, pause, clear, dir_up, preset, digit_q,
        output cnt_enable, cnt_up, cnt_load, cnt_load_value, busy, done, state
    );
endinterface

// File: rtl/decade_timer_ctrl.sv
// Sequencer for a chain of external BCD up/down digit counters: preset load, prescaled stepping, ripple enables, terminal detect.
// Latency: command -> state change in 1 cycle; cnt_enable is combinational from state, divider and digit_q.
// Backpressure: none; pause holds the count and the prescaler phase, clear aborts to an all-zero load.
//
// Ports: clk, reset (sync, active-high); bus (decade_timer_ctrl_if.slave)
//   in : start, pause, clear, dir_up, preset[4*DIGITS], digit_q[4*DIGITS]
//   out: cnt_enable[DIGITS], cnt_up, cnt_load, cnt_load_value[4*DIGITS], busy, done, state[3]
// Optional: define DECADE_TIMER_AUTO_RELOAD_EN to make DONE a one-cycle pulse followed by an automatic reload (periodic timer).
module decade_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    decade_timer_ctrl_if.slave bus
);
    localparam int DW    = 4 * DIGITS;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD   = 3'd2,
        S_RUN    = 3'd3,
        S_PAUSED = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     load_reg, load_d;
    logic              dir_reg, dir_d;
    logic [DIV_W-1:0]  div_cnt, div_d;
    logic              load_q, busy_q, done_q;
    logic              tick, term;
    logic [DIGITS-1:0] at_edge;
    logic [DIGITS-1:0] en;

    // Digits above 9 are not legal BCD; load them as 9 so the counters never start outside 0-9.
    function automatic logic [DW-1:0] clamp_bcd(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // at_edge[i]: digit i sits at its roll-over value for the current direction.
    always_comb begin
        at_edge = '0;
        for (int i = 0; i < DIGITS; i++) begin
            at_edge[i] = dir_reg ? (bus.digit_q[4*i +: 4] == 4'd9)
                                 : (bus.digit_q[4*i +: 4] == 4'd0);
        end
    end

    // Terminal is simply every digit at its roll-over value.
    assign term = &at_edge;
    assign tick = (state_q == S_RUN) && (div_cnt == DIV_LAST);

    // Ripple chain: a digit steps only when every lower digit is about to roll over.
    always_comb begin
        en    = '0;
        en[0] = tick & ~term;
        for (int i = 1; i < DIGITS; i++) begin
            en[i] = en[i-1] & at_edge[i-1];
        end
    end

    // Next-state and datapath decisions. clear overrides everything except reset.
    always_comb begin
        state_d = state_q;
        load_d  = load_reg;
        dir_d   = dir_reg;
        if (bus.clear) begin
            state_d = S_CLEAR;
            load_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_LOAD;
                        load_d  = clamp_bcd(bus.preset);
                        dir_d   = bus.dir_up;
                    end
                end
                S_CLEAR:  state_d = S_IDLE;
                S_LOAD:   state_d = S_RUN;
                S_RUN: begin
                    // A pause request wins over terminal; terminal is re-seen on resume.
                    if (bus.pause) begin
                        state_d = S_PAUSED;
                    end else if (term) begin
                        state_d = S_DONE;
                    end
                end
                S_PAUSED: begin
                    if (!bus.pause) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        state_d = S_LOAD;
                        load_d  = clamp_bcd(bus.preset);
                        dir_d   = bus.dir_up;
                    end else begin
`ifdef DECADE_TIMER_AUTO_RELOAD_EN
                        // Periodic mode: reload with the preset and direction already held.
                        state_d = S_LOAD;
`else
                        state_d = S_DONE;
`endif
                    end
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Prescaler: free-runs only in RUN, frozen in PAUSED so the tick phase survives a pause.
    always_comb begin
        case (state_q)
            S_RUN:    div_d = tick ? '0 : div_cnt + DIV_W'(1);
            S_PAUSED: div_d = div_cnt;
            default:  div_d = '0;
        endcase
    end

    // State, datapath registers and status outputs all update together, so outputs are glitch-free flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            load_reg <= '0;
            dir_reg  <= 1'b0;
            div_cnt  <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            load_reg <= load_d;
            dir_reg  <= dir_d;
            div_cnt  <= div_d;
            load_q   <= (state_d == S_LOAD) || (state_d == S_CLEAR);
            busy_q   <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSED);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign bus.cnt_enable     = en;
    assign bus.cnt_up         = dir_reg;
    assign bus.cnt_load       = load_q;
    assign bus.cnt_load_value = load_reg;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.state          = state_q;
endmodule

// File: tb/tb_decade_timer_ctrl.sv
// Testbench for decade_timer_ctrl: two instances (TICK_DIV=1 and 3) share stimulus, each drives its own behavioural digit bank.
// Latency: all checks happen on the falling edge, between the rising edges that the DUT uses.
// Backpressure: not applicable.
module tb_decade_timer_ctrl;
    localparam int D    = 4;
    localparam int MAXV = 10**D - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           start, pause, clear, dir_up, sel;
    logic [4*D-1:0] preset;
    logic [4*D-1:0] q1 = '0;
    logic [4*D-1:0] q3 = '0;

    int errors = 0;
    int checks = 0;

    decade_timer_ctrl_if #(.DIGITS(D)) b1 ();
    decade_timer_ctrl_if #(.DIGITS(D)) b3 ();

    assign b1.start = start;  assign b1.pause = pause;  assign b1.clear = clear;
    assign b1.dir_up = dir_up; assign b1.preset = preset; assign b1.digit_q = q1;
    assign b3.start = start;  assign b3.pause = pause;  assign b3.clear = clear;
    assign b3.dir_up = dir_up; assign b3.preset = preset; assign b3.digit_q = q3;

    decade_timer_ctrl #(.DIGITS(D), .TICK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    decade_timer_ctrl #(.DIGITS(D), .TICK_DIV(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    // Behavioural BCD counter bank: synchronous load wins, otherwise each enabled digit steps 0-9 with wrap.
    function automatic logic [4*D-1:0] bank_next(input logic [4*D-1:0] q, input logic ld,
                                                 input logic [4*D-1:0] lv, input logic [D-1:0] en,
                                                 input logic up);
        logic [4*D-1:0] r;
        logic [3:0]     d;
        r = q;
        if (ld) begin
            r = lv;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (en[i]) begin
                    d = q[4*i +: 4];
                    if (up) d = (d == 4'd9) ? 4'd0 : d + 4'd1;
                    else    d = (d == 4'd0) ? 4'd9 : d - 4'd1;
                    r[4*i +: 4] = d;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        q1 <= bank_next(q1, b1.cnt_load, b1.cnt_load_value, b1.cnt_enable, b1.cnt_up);
        q3 <= bank_next(q3, b3.cnt_load, b3.cnt_load_value, b3.cnt_enable, b3.cnt_up);
    end

    // Observed outputs of the instance under test.
    logic [D-1:0]   o_en;
    logic [4*D-1:0] o_lv, o_q;
    logic [2:0]     o_st;
    logic           o_up, o_load, o_busy, o_done;
    assign o_en   = sel ? b3.cnt_enable     : b1.cnt_enable;
    assign o_lv   = sel ? b3.cnt_load_value : b1.cnt_load_value;
    assign o_q    = sel ? q3                : q1;
    assign o_st   = sel ? b3.state          : b1.state;
    assign o_up   = sel ? b3.cnt_up         : b1.cnt_up;
    assign o_load = sel ? b3.cnt_load       : b1.cnt_load;
    assign o_busy = sel ? b3.busy           : b1.busy;
    assign o_done = sel ? b3.done           : b1.done;

    // ---------------- reference arithmetic ----------------
    function automatic int clamp_val(input logic [4*D-1:0] raw);
        int n, p, d;
        n = 0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            d = int'(raw[4*i +: 4]);
            if (d > 9) d = 9;
            n += d * p;
            p *= 10;
        end
        return n;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int             x;
        x = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digits that change on one step of value v: digit 0 always, plus one more per trailing 9 (up) or 0 (down).
    function automatic logic [D-1:0] trail_mask(input int v, input logic up);
        logic [D-1:0] m;
        int           x;
        bit           go;
        m    = '0;
        m[0] = 1'b1;
        x    = v;
        go   = 1'b1;
        for (int i = 1; i < D; i++) begin
            if (go && ((up && (x % 10 == 9)) || (!up && (x % 10 == 0)))) begin
                m[i] = 1'b1;
                x    = x / 10;
            end else begin
                go = 1'b0;
            end
        end
        return m;
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full run from start to DONE, checked cycle by cycle against the arithmetic model.
    task automatic run_check(input string name, input logic [4*D-1:0] raw, input logic up,
                             input logic use3, input int pause_at, input int pause_len);
        int             n, t, steps, j, val, nval;
        bit             term_v;
        logic [D-1:0]   exp_en;
        logic [4*D-1:0] exp_lv;
        n      = clamp_val(raw);
        exp_lv = to_bcd(n);
        t      = use3 ? 3 : 1;
        steps  = up ? (MAXV - n) : n;
        sel    = use3;
        do_reset();
        preset = raw; dir_up = up; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({o_st, o_busy, o_done, o_load, o_en, o_up} !== {3'd2, 1'b1, 1'b0, 1'b1, {D{1'b0}}, up}) begin
            errors++;
            $display("FAIL %s load_ctl got st=%0d b=%0b d=%0b ld=%0b en=%b up=%0b want st=2 b=1 d=0 ld=1 en=0 up=%0b",
                     name, o_st, o_busy, o_done, o_load, o_en, o_up, up);
        end
        checks++;
        if (o_lv !== exp_lv) begin
            errors++;
            $display("FAIL %s load_value got=%h want=%h", name, o_lv, exp_lv);
        end
        for (j = 0; j <= steps * t; j++) begin
            @(negedge clk);
            val    = up ? n + j / t : n - j / t;
            term_v = up ? (val == MAXV) : (val == 0);
            exp_en = ((j % t) == t - 1 && !term_v) ? trail_mask(val, up) : '0;
            checks++;
            if ({o_st, o_busy, o_done, o_load, o_en} !== {3'd3, 1'b1, 1'b0, 1'b0, exp_en}) begin
                errors++;
                $display("FAIL %s run j=%0d got st=%0d b=%0b d=%0b ld=%0b en=%b want st=3 b=1 d=0 ld=0 en=%b",
                         name, j, o_st, o_busy, o_done, o_load, o_en, exp_en);
            end
            checks++;
            if (o_q !== to_bcd(val)) begin
                errors++;
                $display("FAIL %s digits j=%0d got=%h want=%h", name, j, o_q, to_bcd(val));
            end
            if (j == pause_at && !term_v) begin
                nval  = up ? n + (j + 1) / t : n - (j + 1) / t;
                pause = 1'b1;
                for (int p = 0; p < pause_len; p++) begin
                    @(negedge clk);
                    if (p == pause_len - 1) pause = 1'b0;
                    checks++;
                    if ({o_st, o_busy, o_en, o_q} !== {3'd4, 1'b1, {D{1'b0}}, to_bcd(nval)}) begin
                        errors++;
                        $display("FAIL %s paused p=%0d got st=%0d b=%0b en=%b q=%h want st=4 b=1 en=0 q=%h",
                                 name, p, o_st, o_busy, o_en, o_q, to_bcd(nval));
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({o_st, o_busy, o_done, o_load, o_en} !== {3'd5, 1'b0, 1'b1, 1'b0, {D{1'b0}}}) begin
            errors++;
            $display("FAIL %s done got st=%0d b=%0b d=%0b ld=%0b en=%b want st=5 b=0 d=1 ld=0 en=0",
                     name, o_st, o_busy, o_done, o_load, o_en);
        end
`ifdef DECADE_TIMER_AUTO_RELOAD_EN
        @(negedge clk);
        checks++;
        if ({o_st, o_done, o_load, o_lv} !== {3'd2, 1'b0, 1'b1, exp_lv}) begin
            errors++;
            $display("FAIL %s reload got st=%0d d=%0b ld=%0b lv=%h want st=2 d=0 ld=1 lv=%h",
                     name, o_st, o_done, o_load, o_lv, exp_lv);
        end
`else
        repeat (3) @(negedge clk);
        checks++;
        if ({o_st, o_done, o_busy} !== {3'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s done_hold got st=%0d d=%0b b=%0b want st=5 d=1 b=0", name, o_st, o_done, o_busy);
        end
`endif
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        checks++;
        if ({o_st, o_busy, o_done, o_load, o_en, o_up, o_lv} !== '0) begin
            errors++;
            $display("FAIL reset_init got st=%0d b=%0b d=%0b ld=%0b en=%b up=%0b lv=%h want all 0",
                     o_st, o_busy, o_done, o_load, o_en, o_up, o_lv);
        end
        preset = 16'h0012; dir_up = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (o_st !== 3'd3) begin
            errors++;
            $display("FAIL reset_prerun got st=%0d want 3", o_st);
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({o_st, o_busy, o_done, o_load, o_en, o_up, o_lv} !== '0) begin
                errors++;
                $display("FAIL reset_midrun k=%0d got st=%0d b=%0b d=%0b ld=%0b en=%b up=%0b lv=%h want all 0",
                         k, o_st, o_busy, o_done, o_load, o_en, o_up, o_lv);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_clear_priority();
        sel = 1'b0;
        do_reset();
        preset = 16'h0012; dir_up = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1; start = 1'b1; preset = 16'h0555;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        checks++;
        if ({o_st, o_load, o_lv, o_busy, o_done, o_en} !== {3'd1, 1'b1, 16'h0000, 1'b0, 1'b0, {D{1'b0}}}) begin
            errors++;
            $display("FAIL clear_state got st=%0d ld=%0b lv=%h b=%0b d=%0b en=%b want st=1 ld=1 lv=0000 b=0 d=0 en=0",
                     o_st, o_load, o_lv, o_busy, o_done, o_en);
        end
        @(negedge clk);
        checks++;
        if ({o_st, o_load, o_q} !== {3'd0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL clear_idle got st=%0d ld=%0b q=%h want st=0 ld=0 q=0000", o_st, o_load, o_q);
        end
        @(negedge clk);
        checks++;
        if (o_st !== 3'd0) begin
            errors++;
            $display("FAIL clear_stays_idle got st=%0d want 0", o_st);
        end
    endtask

    task automatic test_done_behaviour();
        sel = 1'b0;
        do_reset();
        preset = 16'h0002; dir_up = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef DECADE_TIMER_AUTO_RELOAD_EN
        // Period of 5: LOAD, 3 RUN, DONE.
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({o_done, o_load} !== {((c % 5) == 4), ((c % 5) == 0)}) begin
                errors++;
                $display("FAIL auto_period c=%0d got d=%0b ld=%0b want d=%0b ld=%0b",
                         c, o_done, o_load, ((c % 5) == 4), ((c % 5) == 0));
            end
            @(negedge clk);
        end
`else
        repeat (4) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({o_st, o_done} !== {3'd5, 1'b1}) begin
                errors++;
                $display("FAIL done_hold c=%0d got st=%0d d=%0b want st=5 d=1", c, o_st, o_done);
            end
            @(negedge clk);
        end
`endif
        preset = 16'h3B07; dir_up = 1'b1; start = 1'b1;
        // In non-auto mode this lands in DONE; in auto mode it may land in LOAD/RUN. Wait for the next DONE first.
        for (int c = 0; c < 10 && o_st !== 3'd5; c++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({o_st, o_load, o_lv, o_up} !== {3'd2, 1'b1, 16'h3907, 1'b1}) begin
            errors++;
            $display("FAIL restart_from_done got st=%0d ld=%0b lv=%h up=%0b want st=2 ld=1 lv=3907 up=1",
                     o_st, o_load, o_lv, o_up);
        end
    endtask

    task automatic test_random();
        logic [4*D-1:0] raw;
        logic           up, use3;
        int             pa, pl;
        for (int r = 0; r < 8; r++) begin
            up   = 1'($urandom_range(0, 1));
            use3 = 1'($urandom_range(0, 1));
            if (up) raw = {4'($urandom_range(9, 15)), 4'($urandom_range(9, 15)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            else    raw = {8'h00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
            pl = int'($urandom_range(1, 6));
            run_check($sformatf("random%0d", r), raw, up, use3, pa, pl);
        end
    endtask

    initial begin
        sel = 1'b0; preset = '0; dir_up = 1'b0;
        test_reset();
        run_check("down_0012", 16'h0012, 1'b0, 1'b0, -1, 0);
        run_check("up_0199", 16'h0199, 1'b1, 1'b0, -1, 0);
        run_check("prescale_pause", 16'h0005, 1'b0, 1'b1, 4, 10);
        run_check("clamp_00A0", 16'h00A0, 1'b0, 1'b0, -1, 0);
        run_check("terminal_0000", 16'h0000, 1'b0, 1'b0, -1, 0);
        run_check("terminal_FFFF_up", 16'hFFFF, 1'b1, 1'b1, -1, 0);
        test_clear_priority();
        test_done_behaviour();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decade_timer_ctrl.md
Name: decade_timer_ctrl

Overview:
- Sequencing controller for a chain of DIGITS external 4-bit BCD up/down digit counters (0-9 wrap, synchronous load).
- Loads a preset, steps the chain at a prescaled rate, and generates per-digit ripple enables, so digit i steps only when all lower digits are at their roll-over value.
- Detects the terminal count and provides start/pause/clear control. Sits between front-panel/bus control and the digit counter bank.

Parameters:
- DIGITS, 4, number of BCD digit counters controlled (1..8).
- TICK_DIV, 1, clock cycles per count step while running (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start request: latch preset and direction, then run.
- pause  in  1  level: hold count while high.
- clear  in  1  pulse: load all-zero into the digits, then go idle.
- dir_up  in  1  direction, sampled at start: 1=up, 0=down.
- preset  in  4*DIGITS  BCD preset; digit i = bits [4i+3:4i].
- digit_q  in  4*DIGITS  current digit counter outputs.
- cnt_enable  out  DIGITS  per-digit step enable, combinational.
- cnt_up  out  1  direction to all digits (registered dir_reg).
- cnt_load  out  1  load strobe to all digits.
- cnt_load_value  out  4*DIGITS  load data (registered load_reg).
- busy  out  1  high in LOAD, RUN, PAUSED.
- done  out  1  high in DONE.
- state  out  3  FSM state, for debug.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - Next edge gives state=IDLE, load_reg=0, dir_reg=0, div_cnt=0.
  - All outputs are then 0.
- Command priority: reset > clear > start > pause.
- States, with encoding:
  - IDLE=0: wait. start -> LOAD, latching load_reg=clamp(preset) and dir_reg=dir_up.
  - CLEAR=1: cnt_load=1 for one cycle with load_reg=0 -> IDLE.
  - LOAD=2: cnt_load=1 for exactly one cycle, cnt_enable=0 -> RUN. div_cnt cleared.
  - RUN=3: count. pause=1 -> PAUSED. Terminal count -> DONE.
  - PAUSED=4: cnt_enable=0, div_cnt held. pause=0 -> RUN.
  - DONE=5: wait. start -> LOAD (new preset latched).
- clear in any non-reset state: load_reg<=0, next state CLEAR.
- start in RUN or PAUSED is ignored.
- Clamp rule: any preset digit >9 is loaded as 9.
- Digits capture cnt_load_value on the edge where cnt_load=1, independent of cnt_enable. digit_q is valid from the first RUN cycle.
- Tick generation:
  - tick=1 in RUN when div_cnt==TICK_DIV-1. div_cnt then wraps to 0, otherwise increments.
  - With TICK_DIV=1, tick is high every RUN cycle.
- Ripple enables:
  - cnt_enable[0]=tick & ~term.
  - cnt_enable[i]=cnt_enable[i-1] & (digit i-1 == 9 if cnt_up else 0).
- Terminal:
  - term = all digits 9 (up) or all digits 0 (down).
  - Evaluated every RUN cycle, not only on tick.
  - In RUN, term=1 gives no enables and next state DONE.
- Latency: preset N counting down with TICK_DIV=1 gives the sequence start, LOAD, N RUN steps, 1 RUN terminal cycle, DONE.
- Preset already terminal: LOAD, one RUN cycle, DONE. Zero steps issued.
- Reset mid-run:
  - Controller returns to IDLE next edge.
  - Digit values are owned by the digit counters' own reset.
- Multi-bit outputs are driven entirely 0 whenever not meaningful; no X on any output.

Optional Feature:
- Macro: DECADE_TIMER_AUTO_RELOAD_EN.
- Defined:
  - DONE lasts exactly one cycle (done is a one-cycle pulse), then LOAD with the existing load_reg and dir_reg, then RUN.
  - This makes a periodic timer. clear and reset still stop it.
  - start in DONE also reloads, latching the new preset.
- Undefined: DONE holds until start, clear or reset.

Test Plan:
- Reset: assert reset 2 cycles mid-RUN -> next edge state=0, busy=0, done=0, cnt_load=0, cnt_enable=0.
- Down count: DIGITS=4, TICK_DIV=1, preset 0x0012, dir_up=0, start pulse.
  - cnt_load=1 for 1 cycle with value 0x0012.
  - cnt_enable[1] is high only on the step from 10 to 09.
  - done rises after exactly 12 steps, at digit_q=0x0000.
- Up roll-over: preset 0x0199, dir_up=1, TICK_DIV=1.
  - First step has cnt_enable=4'b0111, giving digits 0x0200.
  - Terminal is reached at 0x9999, giving DONE.
- Prescaler/pause: TICK_DIV=3, preset 0x0005 down.
  - Ticks occur every 3rd RUN cycle.
  - Holding pause for 10 cycles gives state=4, cnt_enable=0, and no change to the tick phase on resume.
- Clamp/terminal preset:
  - Preset 0x00A0 loads 0x0090.
  - Preset 0x0000 down gives LOAD, one RUN cycle, DONE with zero enables.
- Clear/priority:
  - clear and start in the same cycle during RUN -> CLEAR with cnt_load=1, value 0x0000, then IDLE.
  - With DECADE_TIMER_AUTO_RELOAD_EN and preset 0x0002 down, done pulses every 5 cycles (LOAD, 3 RUN, DONE).
